// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared constants and TX state encoding for the uart frame link
package uart_link_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - TX FSM and shift register sending a result word MSB-first
module uart_tx_serializer
    import uart_link_pkg::*;
#(
    parameter int TX_BYTES = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [TX_BYTES*BYTE_W-1:0] result_data,
    input  logic                       result_req,
    output logic                       result_ack,
    output logic [BYTE_W-1:0]          tx_din,
    output logic                       tx_wr_en,
    input  logic                       tx_busy,
    output logic                       tx_active
);

    localparam int WORD_W = TX_BYTES * BYTE_W;
    localparam int REM_W  = $clog2(TX_BYTES + 1);

    tx_state_t          r_state;
    tx_state_t          w_next_state;
    logic [WORD_W-1:0]  r_tx_shift;
    logic [REM_W-1:0]   r_rem;
    logic [BYTE_W-1:0]  r_tx_din;
    logic               r_tx_wr_en;
    logic               r_result_ack;
    logic               r_tx_active;
    logic               w_accept;
    logic               w_issue;
    logic               w_byte_done;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= TX_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state: one uart write per byte, paced by the busy high/low handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TX_IDLE:    if (result_req) w_next_state = TX_SEND;
            TX_SEND:    if (!tx_busy)   w_next_state = TX_WAIT_HI;
            TX_WAIT_HI: if (tx_busy)    w_next_state = TX_WAIT_LO;
            TX_WAIT_LO: if (!tx_busy)   w_next_state = (r_rem == REM_W'(1)) ? TX_IDLE : TX_SEND;
            default:                    w_next_state = TX_IDLE;
        endcase
    end

    // Output decode: datapath events derived from the current state
    always_comb begin
        w_accept    = (r_state == TX_IDLE)    && result_req;
        w_issue     = (r_state == TX_SEND)    && !tx_busy;
        w_byte_done = (r_state == TX_WAIT_LO) && !tx_busy;
    end

    // Datapath: latch word on accept, present MSB byte on issue, shift after uart finishes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_shift   <= '0;
            r_rem        <= '0;
            r_tx_din     <= '0;
            r_tx_wr_en   <= 1'b0;
            r_result_ack <= 1'b0;
            r_tx_active  <= 1'b0;
        end else begin
            r_result_ack <= w_accept;
            r_tx_wr_en   <= w_issue;
            if (w_accept) begin
                r_tx_shift  <= result_data;
                r_rem       <= REM_W'(TX_BYTES);
                r_tx_active <= 1'b1;
            end
            if (w_issue) r_tx_din <= r_tx_shift[WORD_W-1 -: BYTE_W];
            if (w_byte_done) begin
                r_tx_shift <= r_tx_shift << BYTE_W;
                r_rem      <= r_rem - REM_W'(1);
                if (r_rem == REM_W'(1)) r_tx_active <= 1'b0;
            end
        end
    end

    assign result_ack = r_result_ack;
    assign tx_din     = r_tx_din;
    assign tx_wr_en   = r_tx_wr_en;
    assign tx_active  = r_tx_active;

endmodule

// File: rtl/uart_frame_link.sv
// rtl/uart_frame_link.sv - full-duplex RX header framer and TX result serializer
module uart_frame_link
    import uart_link_pkg::*;
#(
    parameter int RX_BYTES     = 80,
    parameter int TX_BYTES     = 4,
    parameter int IDLE_TIMEOUT = 5_000_000,
    parameter int CNT_W        = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       rx_rdy,
    input  logic [BYTE_W-1:0]          rx_data,
    output logic                       rx_rdy_clr,
    output logic [BYTE_W-1:0]          tx_din,
    output logic                       tx_wr_en,
    input  logic                       tx_busy,
    output logic [RX_BYTES*BYTE_W-1:0] header_data,
    output logic                       header_valid,
    output logic                       rx_timeout_err,
    output logic [CNT_W-1:0]           byte_count,
    input  logic [TX_BYTES*BYTE_W-1:0] result_data,
    input  logic                       result_req,
    output logic                       result_ack,
    output logic                       tx_active
);

    localparam int HDR_W  = RX_BYTES * BYTE_W;
    localparam int IDX_W  = $clog2(RX_BYTES + 1);
    localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    logic              r_rx_rdy_q;
    logic              r_rx_rdy_clr;
    logic [CNT_W-1:0]  r_byte_count;
    logic [IDX_W-1:0]  r_rx_idx;
    logic [HDR_W-1:0]  r_shadow;
    logic [HDR_W-1:0]  r_header_data;
    logic              r_header_valid;
    logic              r_timeout_err;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_accept;
    logic              w_last;
    logic              w_expire;
    logic [HDR_W-1:0]  w_shadow_next;

    // A byte is taken only on the rising edge of rx_rdy, so a held level counts once
    assign w_accept      = rx_rdy && !r_rx_rdy_q;
    assign w_last        = w_accept && (r_rx_idx == IDX_W'(RX_BYTES - 1));
    assign w_shadow_next = (r_shadow << BYTE_W) | HDR_W'(rx_data);
    assign w_expire      = (IDLE_TIMEOUT != 0) && (r_rx_idx != '0) && !w_accept &&
                           (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT));

    // Edge detect, clear strobe back to the uart, and the running byte counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_rdy_q   <= 1'b0;
            r_rx_rdy_clr <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_rx_rdy_q   <= rx_rdy;
            r_rx_rdy_clr <= w_accept;
            if (w_accept) r_byte_count <= r_byte_count + CNT_W'(1);
        end
    end

    // Framer: shift bytes into the shadow, publish on the last byte, drop partial frames on timeout
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_idx       <= '0;
            r_shadow       <= '0;
            r_header_data  <= '0;
            r_header_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_header_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            if (w_accept) begin
                r_shadow <= w_shadow_next;
                if (w_last) begin
                    r_header_data  <= w_shadow_next;
                    r_header_valid <= 1'b1;
                    r_rx_idx       <= '0;
                end else begin
                    r_rx_idx <= r_rx_idx + IDX_W'(1);
                end
            end else if (w_expire) begin
                r_rx_idx      <= '0;
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Inter-byte idle counter: runs only inside a partial frame and saturates at the limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (w_accept || (r_rx_idx == '0)) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_W'(IDLE_TIMEOUT)) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end

    uart_tx_serializer #(
        .TX_BYTES (TX_BYTES)
    ) u_tx (
        .clock       (clock),
        .reset_n     (reset_n),
        .result_data (result_data),
        .result_req  (result_req),
        .result_ack  (result_ack),
        .tx_din      (tx_din),
        .tx_wr_en    (tx_wr_en),
        .tx_busy     (tx_busy),
        .tx_active   (tx_active)
    );

    assign rx_rdy_clr     = r_rx_rdy_clr;
    assign byte_count     = r_byte_count;
    assign header_data    = r_header_data;
    assign header_valid   = r_header_valid;
    assign rx_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_frame_link.sv
// tb/tb_uart_frame_link.sv - scoreboard bench for uart_frame_link
module tb_uart_frame_link;

    localparam int RXB = 80;
    localparam int TXB = 4;
    localparam int TMO = 100;
    localparam int CW  = 4;
    localparam int HW  = RXB * 8;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            rx_rdy = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_rdy_clr;
    logic [7:0]      tx_din;
    logic            tx_wr_en;
    logic            tx_busy = 1'b0;
    logic [HW-1:0]   header_data;
    logic            header_valid;
    logic            rx_timeout_err;
    logic [CW-1:0]   byte_count;
    logic [TXB*8-1:0] result_data = '0;
    logic            result_req = 1'b0;
    logic            result_ack;
    logic            tx_active;

    uart_frame_link #(
        .RX_BYTES     (RXB),
        .TX_BYTES     (TXB),
        .IDLE_TIMEOUT (TMO),
        .CNT_W        (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx_rdy         (rx_rdy),
        .rx_data        (rx_data),
        .rx_rdy_clr     (rx_rdy_clr),
        .tx_din         (tx_din),
        .tx_wr_en       (tx_wr_en),
        .tx_busy        (tx_busy),
        .header_data    (header_data),
        .header_valid   (header_valid),
        .rx_timeout_err (rx_timeout_err),
        .byte_count     (byte_count),
        .result_data    (result_data),
        .result_req     (result_req),
        .result_ack     (result_ack),
        .tx_active      (tx_active)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [HW-1:0] hdr_q[$];
    int            cnt_q[$];
    logic [7:0]    txb_q[$];
    logic [7:0]    frame[$];
    int            exp_timeouts = 0;
    int            model_count = 0;
    int            ack_count = 0;
    int            wr_count = 0;
    int            low_run = 0;
    int            last_gap = 0;
    logic [HW-1:0] last_hdr = '0;
    logic [HW-1:0] prev_hdr = '0;

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of one accepted byte: count modulo 2^CW, frame of RXB bytes, first byte on top
    task automatic model_accept(input logic [7:0] b);
        logic [HW-1:0] h;
        model_count = (model_count + 1) % (1 << CW);
        cnt_q.push_back(model_count);
        frame.push_back(b);
        if (frame.size() == RXB) begin
            h = '0;
            for (int i = 0; i < RXB; i++) h[(RXB-1-i)*8 +: 8] = frame[i];
            hdr_q.push_back(h);
            frame.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        model_accept(b);
        rx_data = b;
        rx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rx_rdy_clr && n < 50);
        if (n >= 50) check("rx_handshake_timeout", 1'b0, 1'b1);
        @(posedge clock); #1;
        rx_rdy = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
    endtask

    task automatic idle(input int n);
        if (frame.size() != 0 && n > TMO + 10) begin
            exp_timeouts++;
            frame.delete();
        end
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send_result(input logic [TXB*8-1:0] w, input bit hold);
        int start, n;
        start = ack_count;
        result_data = w;
        result_req  = 1'b1;
        n = 0;
        while (ack_count == start && n < 3000) begin @(posedge clock); n++; end
        if (n >= 3000) check("ack_timeout", 1'b0, 1'b1);
        #1;
        if (!hold) result_req = 1'b0;
    endtask

    task automatic wait_tx_done();
        int n;
        n = 0;
        while ((tx_active || txb_q.size() != 0) && n < 3000) begin @(posedge clock); n++; end
        if (n >= 3000) check("tx_done_timeout", 1'b0, 1'b1);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_header_data", header_data, '0);
        check("rst_byte_count", byte_count, '0);
        check("rst_outputs", {header_valid, rx_timeout_err, rx_rdy_clr, tx_wr_en, result_ack, tx_active}, '0);
        check("rst_tx_din", tx_din, '0);
        txb_q.delete();
        cnt_q.delete();
        hdr_q.delete();
        frame.delete();
        model_count = 0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
    endtask

    // RX monitor: byte count per accept, header per frame, timeout pulses, header stability
    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_rdy_clr) begin
                check("clr_expected", cnt_q.size() > 0, 1'b1);
                if (cnt_q.size() > 0) check("byte_count", byte_count, cnt_q.pop_front());
            end
            if (header_valid) begin
                check("header_expected", hdr_q.size() > 0, 1'b1);
                if (hdr_q.size() > 0) check("header_data", header_data, hdr_q.pop_front());
                last_hdr = header_data;
            end else if (header_data !== prev_hdr) begin
                check("header_stable", header_data, prev_hdr);
            end
            if (rx_timeout_err) begin
                check("timeout_expected", exp_timeouts > 0, 1'b1);
                if (exp_timeouts > 0) exp_timeouts--;
            end
        end
        prev_hdr = header_data;
    end

    // Acknowledge monitor: each accepted word queues its bytes MSB-first
    always @(negedge clock) begin
        if (reset_n && result_ack) begin
            check("ack_with_req", result_req, 1'b1);
            check("active_at_ack", tx_active, 1'b1);
            last_gap = low_run;
            ack_count++;
            for (int i = 0; i < TXB; i++) txb_q.push_back(result_data[(TXB-1-i)*8 +: 8]);
        end
        if (tx_active) low_run = 0;
        else           low_run++;
    end

    // Uart transmitter model: checks each written byte and holds busy for 20 clocks
    initial begin
        forever begin
            @(negedge clock);
            if (tx_wr_en) begin
                wr_count++;
                check("wr_en_expected", txb_q.size() > 0, 1'b1);
                if (txb_q.size() > 0) check("tx_din", tx_din, txb_q.pop_front());
                check("active_during_send", tx_active, 1'b1);
                @(posedge clock); #1;
                tx_busy = 1'b1;
                repeat (20) @(posedge clock);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] b;
        int start;
        int n;

        repeat (3) @(posedge clock);
        #1;
        check("init_header_data", header_data, '0);
        check("init_outputs", {header_valid, rx_timeout_err, rx_rdy_clr, tx_wr_en, result_ack, tx_active}, '0);
        check("init_byte_count", byte_count, '0);
        reset_n = 1'b1;
        repeat (2) begin @(posedge clock); #1; end

        // Fixed 80-byte frame with 10-cycle gaps
        for (int i = 0; i < RXB; i++) begin
            if (i == 0)           b = 8'h01;
            else if (i < 4)       b = 8'h00;
            else if (i == RXB-1)  b = 8'h8F;
            else                  b = 8'h80 | 8'(i % 16);
            send_byte(b, 10);
        end
        idle(5);
        check("hdr_first_byte", last_hdr[HW-1 -: 8], 8'h01);
        check("hdr_last_byte", last_hdr[7:0], 8'h8F);
        check("count_after_80", byte_count, 80 % (1 << CW));

        // Partial frame dropped by timeout, then a fresh frame
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 5);
        idle(150);
        check("timeout_seen", exp_timeouts, 0);
        for (int i = 0; i < RXB; i++) send_byte(8'($urandom), $urandom_range(2, 20));
        idle(5);

        // Single result word
        start = wr_count;
        send_result(32'h42A1468F, 1'b0);
        wait_tx_done();
        check("tx_wr_count", wr_count - start, TXB);
        check("tx_din_hold", tx_din, 8'h8F);
        check("tx_active_low", tx_active, 1'b0);

        // Request held through a word; data changed mid-send goes out as the next word
        start = ack_count;
        n = wr_count;
        send_result(32'hDEADBEEF, 1'b1);
        while (wr_count == n) @(posedge clock);
        #1;
        result_data = 32'h13579BDF;
        n = 0;
        while (ack_count < start + 2 && n < 3000) begin @(posedge clock); n++; end
        check("held_req_second_ack", ack_count - start, 2);
        check("held_req_gap", last_gap, 1);
        #1;
        result_req = 1'b0;
        wait_tx_done();

        // Full duplex random traffic
        fork
            begin
                for (int i = 0; i < 2 * RXB; i++) begin
                    send_byte(8'($urandom), $urandom_range(2, 30));
                    if (i == 100) idle(150);
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    send_result($urandom, 1'b0);
                    wait_tx_done();
                    repeat ($urandom_range(0, 15)) @(posedge clock);
                    #1;
                end
            end
        join
        idle(200);

        // Reset mid-frame and mid-second TX byte
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), 3);
        start = wr_count;
        send_result($urandom, 1'b0);
        n = 0;
        while (wr_count < start + 2 && n < 3000) begin @(posedge clock); n++; end
        check("reached_second_byte", wr_count - start, 2);
        repeat (5) @(posedge clock);
        #3;
        do_reset();
        for (int i = 0; i < RXB; i++) send_byte(8'($urandom), 4);
        idle(5);
        check("after_reset_count", byte_count, RXB % (1 << CW));

        // Counter wrap and held rx_rdy
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'($urandom), 3);
        check("count_wrap", byte_count, 1);
        b = 8'($urandom);
        model_accept(b);
        rx_data = b;
        rx_rdy = 1'b1;
        repeat (50) begin @(posedge clock); #1; end
        rx_rdy = 1'b0;
        check("held_rdy_count", byte_count, 2);
        idle(200);

        check("hdr_q_empty", hdr_q.size(), 0);
        check("cnt_q_empty", cnt_q.size(), 0);
        check("txb_q_empty", txb_q.size(), 0);
        check("timeouts_drained", exp_timeouts, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
